pc_unit: RTL

- Parametrised program-counter and performance-counter block for the MIPS core fetch stage.
- Generates the fetch PC with sequential advance, PC-relative branch, absolute jump and exception redirect.
- Supports stall hold, and captures a redirect that arrives during a stall so it is not lost.
- Maintains a free-running cycle counter and a retired-instruction counter, each with a sticky overflow flag and a selectable wrap or saturate mode.

---
 rtl/mips_pkg.sv | 15 +
 rtl/perf_counter.sv | 50 +++++
 rtl/pc_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch-stage PC and performance-counter block.
package mips_pkg;

  localparam int unsigned PC_W_DEFAULT  = 32;
  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam logic [31:0] EXC_VECTOR    = 32'h0000_0080;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    EXC    = 2'd3
  } redirect_kind_e;

endpackage

// File: rtl/perf_counter.sv
// Event counter with sticky overflow flag; wraps or saturates at all-ones.
module perf_counter #(
  parameter int unsigned WIDTH = mips_pkg::CNT_W_DEFAULT,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             at_max;

  assign at_max = &count_q;

  // Clear takes priority over a simultaneous increment.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (inc) begin
      if (at_max) begin
        ovf_d   = 1'b1;
        count_d = SAT ? count_q : '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall-safe redirect capture, plus cycle and
// retired-instruction counters.
module pc_unit
  import mips_pkg::*;
#(
  parameter int unsigned     PC_W         = PC_W_DEFAULT,
  parameter int unsigned     CNT_W        = CNT_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter logic [31:0]     EXC_VEC      = EXC_VECTOR,
  parameter int unsigned     OFFSET_SHIFT = 2,
  parameter bit              SAT_COUNT    = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [PC_W-1:0]   jump_target,
  input  logic              exception,
  input  logic              retire,
  input  logic              count_clr,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus4,
  output logic              redirect_pending,
  output logic              misaligned,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count,
  output logic              cycle_ovf,
  output logic              instret_ovf
);

  localparam logic [PC_W-1:0] EXC_PC = PC_W'(EXC_VEC);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_exc_q, pend_exc_d;
  logic [PC_W-1:0] pend_target_q, pend_target_d;

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] boff_ext;
  logic [PC_W-1:0] branch_pc;
  redirect_kind_e  live_kind;
  logic [PC_W-1:0] live_target;
  logic            live_valid;
  logic            pend_is_exc;

  assign seq_pc    = pc_q + PC_W'(4);
  assign boff_ext  = PC_W'($signed(branch_offset));
  assign branch_pc = seq_pc + (boff_ext << OFFSET_SHIFT);

  always_comb begin
    live_kind   = NONE;
    live_target = seq_pc;
    if (exception) begin
      live_kind   = EXC;
      live_target = EXC_PC;
    end else if (jump) begin
      live_kind   = JUMP;
      live_target = jump_target;
    end else if (branch_taken) begin
      live_kind   = BRANCH;
      live_target = branch_pc;
    end
  end

  assign live_valid  = (live_kind != NONE);
  assign pend_is_exc = pend_valid_q && pend_exc_q;

  // A captured exception beats everything; otherwise a live redirect beats a
  // stale captured one when the stall drops.
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_exc_d    = pend_exc_q;
    pend_target_d = pend_target_q;
    if (!stall) begin
      pend_valid_d = 1'b0;
      pend_exc_d   = 1'b0;
      if (pend_is_exc)       pc_d = pend_target_q;
      else if (live_valid)   pc_d = live_target;
      else if (pend_valid_q) pc_d = pend_target_q;
      else                   pc_d = seq_pc;
    end else if (live_valid && !(pend_is_exc && live_kind != EXC)) begin
      pend_valid_d  = 1'b1;
      pend_exc_d    = (live_kind == EXC);
      pend_target_d = live_target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_exc_q    <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_exc_q    <= pend_exc_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc               = pc_q;
  assign pc_plus4         = seq_pc;
  assign redirect_pending = pend_valid_q;
  assign misaligned       = |pc_q[1:0];

  perf_counter #(.WIDTH(CNT_W), .SAT(SAT_COUNT)) u_cycle (
    .clock (clock),
    .reset (reset),
    .inc   (1'b1),
    .clr   (count_clr),
    .count (cycle_count),
    .ovf   (cycle_ovf)
  );

  perf_counter #(.WIDTH(CNT_W), .SAT(SAT_COUNT)) u_instret (
    .clock (clock),
    .reset (reset),
    .inc   (retire),
    .clr   (count_clr),
    .count (instret_count),
    .ovf   (instret_ovf)
  );

endmodule
